// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared by the fetch unit and the control-unit decoder.
// Holds reset/trap vectors, opcode and funct encodings, the fetch FSM state
// type, the instruction-word layout and the legal-instruction check.
package mips_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] PC_RESET = 32'h0000_0000;
    localparam logic [XLEN-1:0] TRAP_VEC = 32'h0000_0080;

    // Opcodes understood by the decoder
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes understood by the ALU control
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2
    } state_e;

    // R-type field layout; I/J formats overlay rd/shamt/funct
    typedef struct packed {
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] shamt;
        logic [5:0] funct;
    } instr_t;

    // True when the decoder implements this opcode/funct pair
    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] funct);
        logic ok;
        ok = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: ok = 1'b1;
                    default:                               ok = 1'b0;
                endcase
            end
            OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: ok = 1'b1;
            default:                             ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/unidade_busca_if.sv
// unidade_busca_if: instruction-memory handshake, decoder field outputs and
// datapath feedback of the fetch stage.
//   master : fetch unit (drives imem_req/addr, fields, pc, trap, instr_count)
//   slave  : memory + decoder + datapath (drive ack/data, Branch/Jump/Zero,
//            exec_done)
interface unidade_busca_if;
    import mips_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_data;
    logic            instr_valid;
    logic [5:0]      OP;
    logic [5:0]      Funct;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [15:0]     imm;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            Branch;
    logic            Jump;
    logic            Zero;
    logic            exec_done;
    logic            trap;
    logic [XLEN-1:0] instr_count;

    modport master (
        output imem_req, imem_addr, instr_valid, OP, Funct, rs, rt, rd, imm,
               pc, pc_plus4, trap, instr_count,
        input  imem_ack, imem_data, Branch, Jump, Zero, exec_done
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, OP, Funct, rs, rt, rd, imm,
               pc, pc_plus4, trap, instr_count,
        output imem_ack, imem_data, Branch, Jump, Zero, exec_done
    );

endinterface

// File: rtl/unidade_busca_proximo_pc.sv
// proximo_pc: combinational next-PC selection.
//   pc_plus4_i : address of the sequential successor
//   target_i   : IR[25:0] (jump index; low 16 bits are the branch immediate)
//   jump_i, branch_i, zero_i : decoder / ALU flags
//   next_pc_c  : selected next PC (jump > taken branch > sequential)
module proximo_pc (
    input  logic [31:0] pc_plus4_i,
    input  logic [25:0] target_i,
    input  logic        jump_i,
    input  logic        branch_i,
    input  logic        zero_i,
    output logic [31:0] next_pc_c
);

    logic [31:0] br_off;

    // Sign-extended word offset, scaled to bytes
    assign br_off = {{14{target_i[15]}}, target_i[15:0], 2'b00};

    // Jump checked first so an unknown Branch cannot leak into a jump
    always_comb begin
        next_pc_c = pc_plus4_i;
        if (jump_i) begin
            next_pc_c = {pc_plus4_i[31:28], target_i, 2'b00};
        end else if (branch_i && zero_i) begin
            next_pc_c = pc_plus4_i + br_off;
        end
    end

endmodule

// File: rtl/unidade_busca.sv
// unidade_busca: MIPS instruction-fetch stage.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : unidade_busca_if.master (imem handshake, decoder fields,
//                pc/pc_plus4, Branch/Jump/Zero/exec_done, trap, instr_count)
// Build option: define UNIDADE_BUSCA_TRAP_EN to redirect illegal words to
// TRAP_VEC with a one-cycle trap pulse instead of executing them.
module unidade_busca
    import mips_pkg::*;
(
    input logic            clk,
    input logic            rst_n,
    unidade_busca_if.master bus
);

`ifdef UNIDADE_BUSCA_TRAP_EN
    localparam bit TRAP_EN_CFG = 1'b1;
`else
    localparam bit TRAP_EN_CFG = 1'b0;
`endif

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc4_q, pc4_d;
    instr_t          ir_q, ir_d;
    logic            valid_q, valid_d;
    logic            trap_q, trap_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] count_q, count_d;

    logic [XLEN-1:0] ir_w;
    logic [XLEN-1:0] next_pc_c;
    logic            illegal_c;

    assign ir_w = ir_q;

    // Word on imem_data would be rejected by the decoder
    assign illegal_c = TRAP_EN_CFG && !is_legal(bus.imem_data[31:26], bus.imem_data[5:0]);

    proximo_pc u_proximo_pc (
        .pc_plus4_i (pc4_q),
        .target_i   (ir_w[25:0]),
        .jump_i     (bus.Jump),
        .branch_i   (bus.Branch),
        .zero_i     (bus.Zero),
        .next_pc_c  (next_pc_c)
    );

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= PC_RESET;
            pc4_q   <= PC_RESET + 32'd4;
            ir_q    <= '0;
            valid_q <= 1'b0;
            trap_q  <= 1'b0;
            req_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
            ir_q    <= ir_d;
            valid_q <= valid_d;
            trap_q  <= trap_d;
            req_q   <= req_d;
            count_q <= count_d;
        end
    end

    // Next-state and register-update logic
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        ir_d    = ir_q;
        valid_d = valid_q;
        trap_d  = 1'b0;
        count_d = count_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (bus.imem_ack) begin
                    if (illegal_c) begin
                        // Refetch from the trap vector; IR and count untouched
                        pc_d   = TRAP_VEC;
                        pc4_d  = TRAP_VEC + 32'd4;
                        trap_d = 1'b1;
                    end else begin
                        ir_d    = instr_t'(bus.imem_data);
                        valid_d = 1'b1;
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                if (bus.exec_done) begin
                    pc_d    = next_pc_c;
                    pc4_d   = next_pc_c + 32'd4;
                    valid_d = 1'b0;
                    count_d = count_q + 32'd1;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Registered copy of "state is S_FETCH"
        req_d = (state_d == S_FETCH);
    end

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = pc_q;
    assign bus.pc          = pc_q;
    assign bus.pc_plus4    = pc4_q;
    assign bus.instr_valid = valid_q;
    assign bus.trap        = trap_q;
    assign bus.instr_count = count_q;
    assign bus.OP          = ir_w[31:26];
    assign bus.rs          = ir_w[25:21];
    assign bus.rt          = ir_w[20:16];
    assign bus.rd          = ir_w[15:11];
    assign bus.imm         = ir_w[15:0];
    assign bus.Funct       = ir_w[5:0];

endmodule
